audio_i2s_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 9 +
 rtl/audiostream.sv | 13 +
 rtl/audio_edge_gen.sv | 33 +++
 rtl/audio_i2s_tx.sv | 126 ++++++++++++
 tb/tb_audio_i2s_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audiostream types for the CD-i audio path.
// Used by audiofifo sources and the I2S transmitter.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W = 16;

    typedef logic [AUDIO_SAMPLE_W-1:0] audio_sample_t;

endpackage

// File: rtl/audiostream.sv
// audiostream link: source presents write/sample,
// sink pulses strobe to consume one sample.
interface audiostream;
    import audio_pkg::*;

    logic          write;
    audio_sample_t sample;
    logic          strobe;

    modport source (output write, output sample, input strobe);
    modport sink   (input write, input sample, output strobe);

endinterface

// File: rtl/audio_edge_gen.sv
// Fractional phase accumulator producing BCLK edge ticks
// at INC ticks per second from a CLK_FREQ clock.
module audio_edge_gen #(
    parameter int unsigned CLK_FREQ = 30000000,
    parameter int unsigned INC      = 5644800
) (
    input  logic clk,
    input  logic reset_n,
    output logic edge_tick
);

    if (INC >= CLK_FREQ) begin : g_bad_inc
        $error("audio_edge_gen: INC must be below CLK_FREQ");
    end

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [32:0] sum;

    // Add INC each clk; wrap by CLK_FREQ and flag an edge.
    always_comb begin
        sum       = {1'b0, acc_q} + 33'(INC);
        edge_tick = (sum >= 33'(CLK_FREQ));
        acc_d     = edge_tick ? 32'(sum - 33'(CLK_FREQ)) : sum[31:0];
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter fed by two audiostream sinks (left/right).
// AUDIO_I2S_HOLD_ON_UNDERRUN_EN: repeat last pair on underrun.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 30000000,
    parameter int unsigned SAMPLE_RATE = 44100,
    parameter int unsigned SLOT_BITS   = 32
) (
    input  logic      clk,
    input  logic      reset_n,
    audiostream.sink  left,
    audiostream.sink  right,
    output logic      i2s_bclk,
    output logic      i2s_lrclk,
    output logic      i2s_sdata,
    output logic      underrun
);

    localparam int unsigned INC = 4 * SAMPLE_RATE * SLOT_BITS;
    localparam int unsigned CW  = $clog2(2 * SLOT_BITS);
    localparam logic [CW-1:0] LAST = CW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] SLOT = CW'(SLOT_BITS);
    localparam logic [CW-1:0] SW   = CW'(AUDIO_SAMPLE_W);

    if (SLOT_BITS < 17 || SLOT_BITS > 64) begin : g_bad_slot
        $error("audio_i2s_tx: SLOT_BITS must be 17..64");
    end

    logic          tick;
    logic          fall;
    logic          wrap;
    logic          fetch;
    logic          both;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          underrun_q, underrun_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    audio_sample_t hold_l_q, hold_l_d;
    audio_sample_t hold_r_q, hold_r_d;
    logic [CW-1:0] pos;
    logic [3:0]    idx;
    audio_sample_t word;

    audio_edge_gen #(
        .CLK_FREQ (CLK_FREQ),
        .INC      (INC)
    ) u_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .edge_tick (tick)
    );

    assign fall  = tick & bclk_q;
    assign wrap  = (bit_cnt_q == LAST);
    assign fetch = fall & wrap;
    assign both  = left.write & right.write;

    // Both channels are consumed together or not at all.
    assign left.strobe  = fetch & both;
    assign right.strobe = fetch & both;

    // Next state: bit counter, fetch, slot/data serialiser.
    always_comb begin
        bclk_d     = bclk_q ^ tick;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        underrun_d = fetch & ~both;
        pos        = '0;
        idx        = '0;
        word       = '0;
        if (fetch) begin
            if (both) begin
                hold_l_d = left.sample;
                hold_r_d = right.sample;
            end else begin
`ifdef AUDIO_I2S_HOLD_ON_UNDERRUN_EN
                hold_l_d = hold_l_q;
                hold_r_d = hold_r_q;
`else
                hold_l_d = '0;
                hold_r_d = '0;
`endif
            end
        end
        if (fall) begin
            bit_cnt_d = wrap ? '0 : bit_cnt_q + CW'(1);
            lrclk_d   = (bit_cnt_d >= SLOT);
            pos       = lrclk_d ? bit_cnt_d - SLOT : bit_cnt_d;
            word      = lrclk_d ? hold_r_d : hold_l_d;
            idx       = 4'(SW - pos);
            sdata_d   = (pos != '0) && (pos <= SW) && word[idx];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            bit_cnt_q  <= '0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
        end else begin
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed self-checking bench for audio_i2s_tx.
// Monitor decodes the I2S pins; tasks compare.
module tb_audio_i2s_tx;
    import audio_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

    audiostream l_if ();
    audiostream r_if ();

    audio_i2s_tx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .left      (l_if),
        .right     (r_if),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int tb_cnt = 0, fall_cnt = 0, frame_done = 0, cyc = 0;
    int l_stb = 0, r_stb = 0, stb_diff = 0, stb_wide = 0, stb_mis = 0;
    int urun = 0, urun_wide = 0, lr_err = 0, hp_err = 0, hp_len = 0;
    bit hp_valid = 0, prev_bclk = 0, prev_lr = 0, prev_stb = 0;
    bit prev_ur = 0, stb_pend = 0, fell;
    logic [63:0] sd_log = '0;
    logic [63:0] last_frame = '0;
    int rise_q[$];
    int rise_fall[$];

    // Pin-level monitor: bit position, frames, strobes, timing.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            tb_cnt = 0; prev_bclk = 0; prev_lr = 0; prev_stb = 0;
            prev_ur = 0; stb_pend = 0; hp_len = 0; hp_valid = 0;
            sd_log = '0;
            if (l_if.strobe !== 1'b0 || r_if.strobe !== 1'b0) stb_mis++;
        end else begin
            fell = prev_bclk && !i2s_bclk;
            if (stb_pend && !fell) stb_mis++;
            stb_pend = 0;
            if (fell) begin
                tb_cnt = (tb_cnt + 1) % 64;
                fall_cnt++;
                if (tb_cnt == 0) begin
                    last_frame = sd_log;
                    frame_done++;
                end
                sd_log[tb_cnt] = i2s_sdata;
            end
            hp_len++;
            if (i2s_bclk !== prev_bclk) begin
                if (hp_valid && hp_len != 5 && hp_len != 6) hp_err++;
                hp_valid = 1;
                hp_len = 0;
            end
            if (i2s_lrclk !== (tb_cnt >= 32)) lr_err++;
            if (i2s_lrclk && !prev_lr) begin
                rise_q.push_back(cyc);
                rise_fall.push_back(fall_cnt);
            end
            if (l_if.strobe === 1'b1) l_stb++;
            if (r_if.strobe === 1'b1) r_stb++;
            if (l_if.strobe !== r_if.strobe) stb_diff++;
            if (l_if.strobe && prev_stb) stb_wide++;
            if (l_if.strobe) begin
                if (!(i2s_bclk && tb_cnt == 63)) stb_mis++;
                stb_pend = 1;
            end
            if (underrun === 1'b1) urun++;
            if (underrun && prev_ur) urun_wide++;
            prev_bclk = i2s_bclk;
            prev_lr = i2s_lrclk;
            prev_stb = l_if.strobe;
            prev_ur = underrun;
        end
    end

    task automatic wait_frames(input int n);
        int target;
        int t;
        target = frame_done + n;
        t = 0;
        while (frame_done < target && t < n * 700 + 1500) begin
            @(negedge clk); #1;
            t++;
        end
        checks++;
        if (frame_done < target) begin
            failures++;
            $display("FAIL wait_frames got=%0d want=%0d", frame_done, target);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        l_if.write = 1'b0; l_if.sample = '0;
        r_if.write = 1'b0; r_if.sample = '0;
        repeat (4) @(negedge clk);
        #1;
        checks += 6;
        if (i2s_bclk !== 1'b0) begin failures++; $display("FAIL rst_bclk got=%b want=0", i2s_bclk); end
        if (i2s_lrclk !== 1'b0) begin failures++; $display("FAIL rst_lrclk got=%b want=0", i2s_lrclk); end
        if (i2s_sdata !== 1'b0) begin failures++; $display("FAIL rst_sdata got=%b want=0", i2s_sdata); end
        if (underrun !== 1'b0) begin failures++; $display("FAIL rst_underrun got=%b want=0", underrun); end
        if (l_if.strobe !== 1'b0) begin failures++; $display("FAIL rst_lstrobe got=%b want=0", l_if.strobe); end
        if (r_if.strobe !== 1'b0) begin failures++; $display("FAIL rst_rstrobe got=%b want=0", r_if.strobe); end
        reset_n = 1'b1;
    endtask

    task automatic test_rate();
        int base, t, span, hp0, lr0;
        l_if.write = 1'b1; l_if.sample = 16'h1111;
        r_if.write = 1'b1; r_if.sample = 16'h2222;
        @(negedge clk); #1;
        base = rise_q.size();
        hp0 = hp_err; lr0 = lr_err;
        t = 0;
        while (rise_q.size() < base + 101 && t < 71000) begin
            @(negedge clk); #1;
            t++;
        end
        span = (rise_q.size() >= base + 101) ? rise_q[base+100] - rise_q[base] : -1;
        checks += 3;
        if (span < 68026 || span > 68028) begin
            failures++; $display("FAIL rate_span got=%0d want=68027+-1", span);
        end
        if (hp_err != hp0) begin
            failures++; $display("FAIL bclk_halfperiod bad=%0d want=0", hp_err - hp0);
        end
        if (lr_err != lr0) begin
            failures++; $display("FAIL lrclk_slot bad=%0d want=0", lr_err - lr0);
        end
    endtask

    task automatic test_data();
        logic [15:0] lw, rw;
        logic lz, rz;
        @(negedge clk); #1;
        l_if.sample = 16'h8001;
        r_if.sample = 16'h7FFE;
        wait_frames(2);
        lz = last_frame[0];
        rz = last_frame[32];
        for (int i = 1; i <= 16; i++) begin
            lw[16-i] = last_frame[i];
            rw[16-i] = last_frame[32+i];
        end
        for (int i = 17; i < 32; i++) begin
            lz = lz | last_frame[i];
            rz = rz | last_frame[32+i];
        end
        checks += 4;
        if (lw !== 16'h8001) begin failures++; $display("FAIL data_left got=%h want=8001", lw); end
        if (rw !== 16'h7FFE) begin failures++; $display("FAIL data_right got=%h want=7ffe", rw); end
        if (lz !== 1'b0) begin failures++; $display("FAIL pad_left got=%b want=0", lz); end
        if (rz !== 1'b0) begin failures++; $display("FAIL pad_right got=%b want=0", rz); end
    endtask

    task automatic test_handshake();
        int l0, r0, d0, w0, m0;
        l0 = l_stb; r0 = r_stb; d0 = stb_diff; w0 = stb_wide; m0 = stb_mis;
        wait_frames(10);
        checks += 5;
        if (l_stb - l0 != 10) begin failures++; $display("FAIL hs_lcount got=%0d want=10", l_stb - l0); end
        if (r_stb - r0 != 10) begin failures++; $display("FAIL hs_rcount got=%0d want=10", r_stb - r0); end
        if (stb_diff != d0) begin failures++; $display("FAIL hs_same got=%0d want=0", stb_diff - d0); end
        if (stb_wide != w0) begin failures++; $display("FAIL hs_width got=%0d want=0", stb_wide - w0); end
        if (stb_mis != m0) begin failures++; $display("FAIL hs_align got=%0d want=0", stb_mis - m0); end
    endtask

    task automatic test_underrun();
        int l0, r0, u0, w0;
        logic [15:0] lw, rw, exp_l, exp_r;
`ifdef AUDIO_I2S_HOLD_ON_UNDERRUN_EN
        exp_l = 16'h8001; exp_r = 16'h7FFE;
`else
        exp_l = 16'h0000; exp_r = 16'h0000;
`endif
        l0 = l_stb; r0 = r_stb; u0 = urun; w0 = urun_wide;
        l_if.sample = 16'h1234;
        r_if.sample = 16'h5555;
        r_if.write = 1'b0;
        wait_frames(1);
        checks += 4;
        if (l_stb != l0) begin failures++; $display("FAIL ur_lstrobe got=%0d want=0", l_stb - l0); end
        if (r_stb != r0) begin failures++; $display("FAIL ur_rstrobe got=%0d want=0", r_stb - r0); end
        if (urun - u0 != 1) begin failures++; $display("FAIL ur_pulse got=%0d want=1", urun - u0); end
        if (urun_wide != w0) begin failures++; $display("FAIL ur_width got=%0d want=0", urun_wide - w0); end
        wait_frames(1);
        for (int i = 1; i <= 16; i++) begin
            lw[16-i] = last_frame[i];
            rw[16-i] = last_frame[32+i];
        end
        checks += 2;
        if (lw !== exp_l) begin failures++; $display("FAIL ur_left got=%h want=%h", lw, exp_l); end
        if (rw !== exp_r) begin failures++; $display("FAIL ur_right got=%h want=%h", rw, exp_r); end
        r_if.write = 1'b1;
    endtask

    task automatic test_reset_mid();
        int t, f0, s0, rs0, rpos;
        t = 0;
        while (tb_cnt != 20 && t < 1500) begin
            @(negedge clk); #1;
            t++;
        end
        checks++;
        if (tb_cnt != 20) begin failures++; $display("FAIL rm_reach got=%0d want=20", tb_cnt); end
        reset_n = 1'b0;
        #1;
        checks += 5;
        if (i2s_bclk !== 1'b0) begin failures++; $display("FAIL rm_bclk got=%b want=0", i2s_bclk); end
        if (i2s_lrclk !== 1'b0) begin failures++; $display("FAIL rm_lrclk got=%b want=0", i2s_lrclk); end
        if (i2s_sdata !== 1'b0) begin failures++; $display("FAIL rm_sdata got=%b want=0", i2s_sdata); end
        if (underrun !== 1'b0) begin failures++; $display("FAIL rm_underrun got=%b want=0", underrun); end
        if (l_if.strobe !== 1'b0 || r_if.strobe !== 1'b0) begin
            failures++; $display("FAIL rm_strobe got=%b%b want=00", l_if.strobe, r_if.strobe);
        end
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        f0 = fall_cnt; s0 = l_stb; rs0 = rise_fall.size();
        t = 0;
        while (l_stb == s0 && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        rpos = (rise_fall.size() == rs0 + 1) ? rise_fall[rs0] - f0 : -1;
        checks += 3;
        if (fall_cnt - f0 != 63) begin
            failures++; $display("FAIL rm_first_strobe falls=%0d want=63", fall_cnt - f0);
        end
        if (r_stb != l_stb) begin
            failures++; $display("FAIL rm_pair l=%0d r=%0d want equal", l_stb, r_stb);
        end
        if (rpos != 32) begin
            failures++; $display("FAIL rm_first_lrclk falls=%0d want=32", rpos);
        end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_data();
        test_handshake();
        test_underrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
